// File: rtl/pipe_add_acc.sv
// pipe_add_acc: pipelined W-bit unsigned adder with a saturating running
// accumulate mode and valid/ready flow control on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   enable     1 = accept input beats; 0 = in_ready low, pipeline drains
//   in_valid   input beat present
//   in_ready   block can take a beat this cycle
//   in_a/in_b  W-bit unsigned operands
//   mode       sampled with the beat: 0 = add, 1 = accumulate
//   clear      synchronous clear of accumulator and overflow flag
//   out_valid  result present (last pipeline stage)
//   out_ready  consumer takes the result
//   out        ACC_W-bit unsigned result
//   overflow   sticky flag: accumulator has saturated
//
// Parameter constraints: ACC_W >= W+1, STAGES >= 1.
module pipe_add_acc #(
    parameter int unsigned W      = 7,
    parameter int unsigned ACC_W  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             mode,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out,
    output logic             overflow
);

    logic [STAGES-1:0] vld_q;
    logic [ACC_W-1:0]  dat_q [STAGES];
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              ovf_q, ovf_d;

    logic              advance;
    logic              accept;
    logic [W:0]        sum;
    logic [ACC_W-1:0]  sum_ext;
    logic [ACC_W-1:0]  acc_base;
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  stage1_d;

    // Global stall: every stage moves only when the output slot is free
    // or being consumed this cycle.
    assign advance  = !vld_q[STAGES-1] || out_ready;
    assign in_ready = enable && advance;
    assign accept   = in_valid && in_ready;

    assign sum      = {1'b0, in_a} + {1'b0, in_b};
    assign sum_ext  = ACC_W'(sum);
    // Clear takes effect before an accumulate arriving in the same cycle.
    assign acc_base = clear ? '0 : acc_q;
    assign acc_sum  = {1'b0, acc_base} + {1'b0, sum_ext};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
        if (accept && mode) begin
            if (acc_sum[ACC_W]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_W-1:0];
            end
        end
    end

    assign stage1_d = mode ? acc_d : sum_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            // Accumulator state is independent of the stall so that a
            // clear is never lost while the output is back-pressured.
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            if (advance) begin
                vld_q[0] <= accept;
                if (accept) begin
                    dat_q[0] <= stage1_d;
                end
                for (int unsigned i = 1; i < STAGES; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out       = dat_q[STAGES-1];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_add_acc.sv
// Self-checking bench for pipe_add_acc: directed scenarios followed by a
// randomized phase, checked against a queue-based reference model.
module tb_pipe_add_acc;

    localparam int W      = 7;
    localparam int ACC_W  = 8;
    localparam int STAGES = 2;
    localparam int MAXV   = (1 << ACC_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             mode;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out;
    logic             overflow;

    pipe_add_acc #(
        .W      (W),
        .ACC_W  (ACC_W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mode      (mode),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: expected results in acceptance order, plus acc/flag.
    int sb[$];
    int m_acc = 0;
    int m_ovf = 0;

    logic             s_in_ready, s_out_valid, s_acc_beat;
    logic [ACC_W-1:0] s_out;
    int               last_out = -1;
    int               nout = 0;
    logic             prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_out = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle. Entered at a falling edge with inputs already driven;
    // samples just before the rising edge, updates the model, returns at the
    // next falling edge.
    task automatic cyc();
        int sum;
        #4;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out       = out;
        chk("in_ready_rule", in_ready, enable && (!out_valid || out_ready));
        chk("overflow", overflow, m_ovf);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", out, prev_out);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_valid, 0);
            end else begin
                last_out = sb.pop_front();
                chk("out_data", out, last_out);
            end
            nout++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = out;
        s_acc_beat = in_valid && in_ready;
        if (clear) begin
            m_acc = 0;
            m_ovf = 0;
        end
        if (s_acc_beat) begin
            sum = int'(in_a) + int'(in_b);
            if (mode) begin
                m_acc = m_acc + sum;
                if (m_acc > MAXV) begin
                    m_acc = MAXV;
                    m_ovf = 1;
                end
                sb.push_back(m_acc);
            end else begin
                sb.push_back(sum);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int a, input int b, input logic m, input logic c);
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        mode     = m;
        clear    = c;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (s_acc_beat) break;
        end
        if (!s_acc_beat) chk("send_timeout", s_acc_beat, 1);
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (sb.size() == 0) break;
            cyc();
        end
        chk("drain_empty", sb.size(), 0);
        cyc();
        chk("drain_idle", s_out_valid, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        mode      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_overflow", overflow, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Test 1: plain add, latency STAGES
        in_valid = 1'b1; in_a = 7'd100; in_b = 7'd27; mode = 1'b0;
        cyc();
        chk("t1_accept", s_acc_beat, 1);
        in_valid = 1'b0;
        cyc();
        chk("t1_lat_c1", s_out_valid, 0);
        cyc();
        chk("t1_lat_c2", s_out_valid, 1);
        chk("t1_out", s_out, 127);
        send(127, 127, 1'b0, 1'b0);
        drain();
        chk("t1_out254", last_out, 254);
        chk("t1_ovf", overflow, 0);

        // Test 2: back-pressure with beats in flight
        nout = 0;
        in_valid = 1'b1; mode = 1'b0;
        in_a = 7'd1; in_b = 7'd1;
        cyc();
        in_a = 7'd2; in_b = 7'd2;
        cyc();
        in_a = 7'd3; in_b = 7'd3; out_ready = 1'b0;
        cyc();
        chk("t2_hold_out", s_out, 2);
        chk("t2_hold_rdy", s_in_ready, 0);
        cyc();
        chk("t2_hold_out2", s_out, 2);
        chk("t2_hold_rdy2", s_in_ready, 0);
        out_ready = 1'b1;
        cyc();
        chk("t2_accept3", s_acc_beat, 1);
        in_valid = 1'b0;
        drain();
        chk("t2_count", nout, 3);
        chk("t2_last", last_out, 6);

        // Test 3: accumulate up to saturation
        send(10, 5, 1'b1, 1'b0);    drain(); chk("t3_15", last_out, 15);
        send(20, 0, 1'b1, 1'b0);    drain(); chk("t3_35", last_out, 35);
        send(100, 100, 1'b1, 1'b0); drain(); chk("t3_235", last_out, 235);
        send(20, 5, 1'b1, 1'b0);    drain(); chk("t3_sat", last_out, 255);
        chk("t3_ovf_set", overflow, 1);
        send(1, 0, 1'b1, 1'b0);     drain(); chk("t3_sat2", last_out, 255);
        chk("t3_ovf_sticky", overflow, 1);

        // Test 4: clear together with an accumulate beat
        send(1, 2, 1'b1, 1'b1); drain(); chk("t4_3", last_out, 3);
        chk("t4_ovf_clr", overflow, 0);
        send(4, 0, 1'b1, 1'b0); drain(); chk("t4_7", last_out, 7);

        // Test 5: enable low drains in-flight results, accepts nothing
        in_valid = 1'b1; mode = 1'b0;
        in_a = 7'd5; in_b = 7'd5;
        cyc();
        in_a = 7'd6; in_b = 7'd6;
        cyc();
        enable = 1'b0;
        nout   = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t5_in_ready", s_in_ready, 0);
            chk("t5_no_accept", s_acc_beat, 0);
        end
        chk("t5_drained", nout, 2);
        chk("t5_last", last_out, 12);
        in_valid = 1'b0;
        enable   = 1'b1;

        // Test 6: reset mid-stream
        in_valid = 1'b1; mode = 1'b1; clear = 1'b1;
        in_a = 7'd25; in_b = 7'd25;
        cyc();
        clear = 1'b0; mode = 1'b0;
        in_a = 7'd1; in_b = 7'd1;
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ovf", overflow, 0);
        chk("t6_rst_out", out, 0);
        sb.delete();
        m_acc = 0;
        m_ovf = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(3, 4, 1'b1, 1'b0);
        drain();
        chk("t6_acc_cleared", last_out, 7);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = W'($urandom_range(0, (1 << W) - 1));
            in_b      = W'($urandom_range(0, (1 << W) - 1));
            mode      = ($urandom_range(0, 1) != 0);
            clear     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        clear  = 1'b0;
        enable = 1'b1;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
